// File: rtl/wdt_pkg.sv
// wdt_pkg: shared watchdog types, register map and key constants
package wdt_pkg;
  typedef enum logic [1:0] {DISABLED = 2'd0, ARMED = 2'd1, WARN = 2'd2, BITE = 2'd3} wdt_state_t;
  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_LOAD = 2'd1;
  localparam logic [1:0] ADDR_KICK = 2'd2;
  localparam int CTRL_EN = 0;
  localparam int CTRL_LOCK = 1;
  localparam logic [31:0] DEF_KICK_KEY = 32'h5A5A_5A5A;
endpackage

// File: rtl/wdt_stuck_detect.sv
// wdt_stuck_detect: counts consecutive unstalled cycles with an unchanged PC
// clk/rst (async active-low), i_pc/i_stall from the core, i_clr clears the run,
// o_stuck is high once the run length reaches STUCK_CYCLES.
module wdt_stuck_detect #(
  parameter int STUCK_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_pc,
  input  logic        i_stall,
  input  logic        i_clr,
  output logic        o_stuck
);
  logic [31:0] r_prev_pc, r_cnt;
  assign o_stuck = r_cnt == 32'(STUCK_CYCLES);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_prev_pc <= '0;
      r_cnt     <= '0;
    end else begin
      r_prev_pc <= i_pc;
      r_cnt     <= (i_clr || i_pc != r_prev_pc) ? '0 :
                   (i_stall || o_stuck)         ? r_cnt : r_cnt + 32'd1;
    end
endmodule

// File: rtl/pc_watchdog.sv
// pc_watchdog: forward-progress watchdog for the RV32I core (arm, kick, warn, bite)
// clk, rst (async active-low); pc_value/stall from program_counter;
// wdt_wr_en/addr/data register port (0=CTRL, 1=LOAD, 2=KICK);
// wdt_irq warning level, wdt_rst_n bite pulse, wdt_state/count/bite_cnt status.
// Optional PC-stuck detection is built when WDT_PC_STUCK_EN is defined.
module pc_watchdog
  import wdt_pkg::*;
#(
  parameter logic [31:0] PROG_VALUE  = 32'd348,
  parameter logic [31:0] DEF_LOAD    = 32'd1000,
  parameter logic [31:0] WARN_CYCLES = 32'd64,
  parameter logic [31:0] BITE_CYCLES = 32'd4,
  parameter logic [31:0] KICK_KEY    = DEF_KICK_KEY
`ifdef WDT_PC_STUCK_EN
  , parameter int STUCK_CYCLES = 256
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_value,
  input  logic        stall,
  input  logic        wdt_wr_en,
  input  logic [1:0]  wdt_wr_addr,
  input  logic [31:0] wdt_wr_data,
  output logic        wdt_irq,
  output logic        wdt_rst_n,
  output logic [1:0]  wdt_state,
  output logic [31:0] wdt_count,
  output logic [7:0]  wdt_bite_cnt
);
  wdt_state_t  r_state;
  logic [31:0] r_count, r_load;
  logic        r_lock, r_irq, r_rst_n;
  logic [7:0]  r_bite_cnt;
  logic        w_live, w_ctrl_wr, w_load_wr, w_kick, w_done, w_stuck;
  assign w_live    = r_state == ARMED || r_state == WARN;
  assign w_ctrl_wr = wdt_wr_en && wdt_wr_addr == ADDR_CTRL && !r_lock;
  assign w_load_wr = wdt_wr_en && wdt_wr_addr == ADDR_LOAD && !r_lock;
  assign w_kick    = wdt_wr_en && wdt_wr_addr == ADDR_KICK && wdt_wr_data == KICK_KEY && w_live;
  assign w_done    = w_live && pc_value >= PROG_VALUE;
`ifdef WDT_PC_STUCK_EN
  wdt_stuck_detect #(.STUCK_CYCLES(STUCK_CYCLES)) u_stuck (
    .clk     (clk),
    .rst     (rst),
    .i_pc    (pc_value),
    .i_stall (stall),
    .i_clr   (w_kick || (r_state == ARMED && w_stuck)),
    .o_stuck (w_stuck)
  );
`else
  logic w_unused_stall;
  assign w_unused_stall = stall;
  assign w_stuck = 1'b0;
`endif
  assign wdt_state    = r_state;
  assign wdt_count    = r_count;
  assign wdt_irq      = r_irq;
  assign wdt_rst_n    = r_rst_n;
  assign wdt_bite_cnt = r_bite_cnt;
  // Enable lives in the state itself: anything but DISABLED is enabled.
  // Branch order inside ARMED/WARN encodes completion > disable > kick > expiry.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state    <= DISABLED;
      r_count    <= '0;
      r_load     <= DEF_LOAD;
      r_lock     <= 1'b0;
      r_irq      <= 1'b0;
      r_rst_n    <= 1'b1;
      r_bite_cnt <= '0;
    end else begin
      if (w_load_wr) r_load <= (wdt_wr_data == '0) ? 32'd1 : wdt_wr_data;
      if (w_ctrl_wr) r_lock <= wdt_wr_data[CTRL_LOCK];
      case (r_state)
        DISABLED:
          if (w_ctrl_wr && wdt_wr_data[CTRL_EN]) begin
            r_state <= ARMED;
            r_count <= r_load;
          end
        BITE:
          if (r_count == 32'd1) begin
            r_state <= ARMED;
            r_count <= r_load;
            r_rst_n <= 1'b1;
          end else r_count <= r_count - 32'd1;
        default:
          if (w_done || (w_ctrl_wr && !wdt_wr_data[CTRL_EN])) begin
            r_state <= DISABLED;
            r_count <= '0;
            r_irq   <= 1'b0;
          end else if (w_kick) begin
            r_state <= ARMED;
            r_count <= r_load;
            r_irq   <= 1'b0;
          end else if (r_state == ARMED && (r_count == 32'd1 || w_stuck)) begin
            r_state <= WARN;
            r_count <= WARN_CYCLES;
            r_irq   <= 1'b1;
          end else if (r_state == WARN && r_count == 32'd1) begin
            r_state    <= BITE;
            r_count    <= BITE_CYCLES;
            r_irq      <= 1'b0;
            r_rst_n    <= 1'b0;
            r_bite_cnt <= (r_bite_cnt == 8'hFF) ? r_bite_cnt : r_bite_cnt + 8'd1;
          end else r_count <= r_count - 32'd1;
      endcase
    end
endmodule
